input_conditioner: RTL and testbench

Synchronises, debounces and edge-detects the dedicated user inputs before the design core sees them. It sits between the `ui_in` pins of the `tt_um_mine` top level and the core logic. It turns raw, asynchronous, bouncy button and switch levels into clean per-bit levels and single-cycle rise and fall pulses. It is instantiated once, directly on `ui_in`, inside the top-level wrapper.

---
 rtl/tt_io_pkg.sv | 17 +
 rtl/debounce_bit.sv | 72 +++++++
 rtl/input_conditioner.sv | 48 ++++
 tb/tb_input_conditioner.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tt_io_pkg.sv
// Shared constants and helpers for conditioning the dedicated user inputs.
package tt_io_pkg;

  // Number of dedicated user input pins on the wrapper.
  localparam int unsigned UI_WIDTH = 8;

  // Default debounce window in clock cycles.
  localparam int unsigned DB_CYCLES_DEFAULT = 1000;

  // Counter width needed to hold 0..db_cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned db_cycles);
    int unsigned w;
    w = $clog2(db_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit conditioner: 2-flop synchroniser, debounce counter, stable level
// and registered rise/fall pulses.
module debounce_bit
  import tt_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ena_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  // Next-cycle pulse, lets the parent register its OR alongside the pulses.
  output logic pulse_d_o
);

  localparam int unsigned CntW = cnt_width(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  // Debounce next-state: count consecutive mismatches, flip when the window fills.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!ena_i) begin
      cnt_d = '0;
    end else if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      cnt_d   = '0;
      rise_d  = sync2_q;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State registers; the synchroniser runs regardless of enable.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pulse_d_o = rise_d | fall_d;

endmodule

// File: rtl/input_conditioner.sv
// Conditions the raw user inputs into debounced levels plus edge pulses, and
// flags any edge on any bit with a coincident registered changed_out.
module input_conditioner
  import tt_io_pkg::*;
#(
  parameter int unsigned WIDTH     = UI_WIDTH,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             changed_out
);

  logic [WIDTH-1:0] pulse_d;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_debounce_bit (
      .clk_i     (clk),
      .reset_i   (reset),
      .ena_i     (ena),
      .raw_i     (raw_in[i]),
      .level_o   (level_out[i]),
      .rise_o    (rise_out[i]),
      .fall_o    (fall_out[i]),
      .pulse_d_o (pulse_d[i])
    );
  end

  // Register the OR of next-cycle pulses so it lands with the pulses themselves.
  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |pulse_d;
    end
  end

  assign changed_out = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench: the driver pushes hand-computed expected outputs for each
// edge, an independent monitor pops and compares just after every edge.
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic       ena;
  logic [7:0] raw_in;
  logic [7:0] level_out;
  logic [7:0] rise_out;
  logic [7:0] fall_out;
  logic       changed_out;

  typedef struct {
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  input_conditioner #(
    .WIDTH     (8),
    .DB_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .raw_in      (raw_in),
    .level_out   (level_out),
    .rise_out    (rise_out),
    .fall_out    (fall_out),
    .changed_out (changed_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the next edge and push what the outputs must be after it.
  task automatic cyc(input logic r, input logic e, input logic [7:0] raw,
                     input logic [7:0] lvl, input logic [7:0] rs, input logic [7:0] fl,
                     input logic ch, input string nm);
    exp_t x;
    @(negedge clk);
    reset  = r;
    ena    = e;
    raw_in = raw;
    x.level = lvl;
    x.rise  = rs;
    x.fall  = fl;
    x.chg   = ch;
    x.name  = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: outputs are always presented, so compare after every edge with a pending entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (level_out !== x.level || rise_out !== x.rise || fall_out !== x.fall ||
            changed_out !== x.chg) begin
          errors++;
          $display("FAIL %s: got lvl=%h rise=%h fall=%h chg=%b, want lvl=%h rise=%h fall=%h chg=%b",
                   x.name, level_out, rise_out, fall_out, changed_out,
                   x.level, x.rise, x.fall, x.chg);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    reset  = 1'b1;
    ena    = 1'b0;
    raw_in = 8'h00;

    // 1: reset held with all inputs high, then release.
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, "reset_hold");
    cyc(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, "reset_release");
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, "idle");

    // 2: clean rise on bit 0, flip after edge 5.
    for (int i = 0; i <= 4; i++) cyc(0, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0, "rise_wait");
    cyc(0, 1, 8'h01, 8'h01, 8'h01, 8'h00, 1, "rise_pulse");
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0, "rise_after");

    // 3: bit 3 glitch of 3 cycles is rejected.
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h09, 8'h01, 8'h00, 8'h00, 0, "glitch_hi");
    for (int i = 0; i < 17; i++) cyc(0, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0, "glitch_lo");

    // 4: bit 7 rises while bit 0 falls, same edge.
    for (int i = 0; i <= 4; i++) cyc(0, 1, 8'h80, 8'h01, 8'h00, 8'h00, 0, "simul_wait");
    cyc(0, 1, 8'h80, 8'h80, 8'h80, 8'h01, 1, "simul_pulse");
    cyc(0, 1, 8'h80, 8'h80, 8'h00, 8'h00, 0, "simul_after");

    // 5: bit 2 counts 3 edges (2..4), ena low for edges 5..9, back at edge e=10.
    for (int i = 0; i <= 4; i++) cyc(0, 1, 8'h84, 8'h80, 8'h00, 8'h00, 0, "ena_count");
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h84, 8'h80, 8'h00, 8'h00, 0, "ena_low");
    for (int i = 0; i < 3; i++) cyc(0, 1, 8'h84, 8'h80, 8'h00, 8'h00, 0, "ena_recount");
    cyc(0, 1, 8'h84, 8'h84, 8'h04, 8'h00, 1, "ena_pulse");
    cyc(0, 1, 8'h84, 8'h84, 8'h00, 8'h00, 0, "ena_after");

    // 6: all bits high, reset at edge 4 with cnt=2, r=5, flip at r+5.
    for (int i = 0; i < 4; i++) cyc(0, 1, 8'hFF, 8'h84, 8'h00, 8'h00, 0, "rstmid_count");
    cyc(1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, "rstmid_reset");
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, "rstmid_wait");
    cyc(0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1, "rstmid_pulse");
    cyc(0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0, "rstmid_after");

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
